// File: rtl/fp_dl16_to_int.sv
// rtl/fp_dl16_to_int.sv - DLFloat16 to signed 16-bit integer converter, one shift per cycle (optional macro: DL16_ROUND_NEAREST_EN)
module fp_dl16_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        overflow,
    output logic        invalid,
    output logic        inexact
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN, DONE} state_t;
    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_OVF, CLS_INV} cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic        sign_q, sign_d;
    logic        left_q, left_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] mag_q, mag_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic [15:0] result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        invalid_q, invalid_d;
    logic        inexact_q, inexact_d;

    logic [5:0]  exp_w;
    logic [8:0]  man_w;
    logic        round_up;
    logic [16:0] rnd_mag;

    assign exp_w = a[14:9];
    assign man_w = a[8:0];

`ifdef DL16_ROUND_NEAREST_EN
    // Half-to-even: round up above the halfway point, or exactly on it when the kept LSB is odd.
    assign round_up = guard_q & (sticky_q | mag_q[0]);
`else
    assign round_up = 1'b0;
`endif

    // Rounded magnitude keeps a carry bit so a round-up past the range can be caught.
    assign rnd_mag = {1'b0, mag_q} + {16'd0, round_up};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign invalid   = invalid_q;
    assign inexact   = inexact_q;

    // Next-state and datapath: classify on accept, shift serially, round/sign in FIN.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        sign_d     = sign_q;
        left_d     = left_q;
        count_d    = count_q;
        mag_d      = mag_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        invalid_d  = invalid_q;
        inexact_d  = inexact_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = SHIFT;
                    sign_d   = a[15];
                    left_d   = 1'b0;
                    count_d  = 4'd0;
                    mag_d    = 16'd0;
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    if (a == 16'hFFFF) begin
                        cls_d = CLS_INV;
                    end else if (exp_w == 6'd0) begin
                        // Subnormals flush to zero; any dropped mantissa makes it inexact.
                        cls_d    = CLS_ZERO;
                        sticky_d = |man_w;
                    end else if (exp_w >= 6'd47 ||
                                 (exp_w == 6'd46 && !(a[15] && man_w == 9'd0))) begin
                        cls_d = CLS_OVF;
                    end else begin
                        cls_d = CLS_NORM;
                        mag_d = {6'd0, 1'b1, man_w};
                        if (exp_w >= 6'd40) begin
                            left_d  = 1'b1;
                            count_d = 4'(exp_w - 6'd40);
                        end else begin
                            // Eleven right shifts already push the hidden bit into sticky.
                            count_d = (exp_w <= 6'd29) ? 4'd11 : 4'(6'd40 - exp_w);
                        end
                    end
                end
            end
            SHIFT: begin
                if (count_q == 4'd0) begin
                    state_d = FIN;
                end else begin
                    count_d = count_q - 4'd1;
                    if (left_q) begin
                        mag_d = mag_q << 1;
                    end else begin
                        mag_d    = mag_q >> 1;
                        guard_d  = mag_q[0];
                        sticky_d = sticky_q | guard_q;
                    end
                end
            end
            FIN: begin
                state_d    = DONE;
                overflow_d = 1'b0;
                invalid_d  = 1'b0;
                inexact_d  = guard_q | sticky_q;
                case (cls_q)
                    CLS_INV: begin
                        result_d  = 16'h7FFF;
                        invalid_d = 1'b1;
                        inexact_d = 1'b0;
                    end
                    CLS_OVF: begin
                        result_d   = sign_q ? 16'h8000 : 16'h7FFF;
                        overflow_d = 1'b1;
                        inexact_d  = 1'b0;
                    end
                    CLS_ZERO: begin
                        result_d = 16'h0000;
                    end
                    default: begin
                        // Negative side reaches one further than positive (-32768).
                        if (rnd_mag > (sign_q ? 17'd32768 : 17'd32767)) begin
                            result_d   = sign_q ? 16'h8000 : 16'h7FFF;
                            overflow_d = 1'b1;
                        end else begin
                            result_d = sign_q ? (~rnd_mag[15:0] + 16'd1) : rnd_mag[15:0];
                        end
                    end
                endcase
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cls_q      <= CLS_NORM;
            sign_q     <= 1'b0;
            left_q     <= 1'b0;
            count_q    <= 4'd0;
            mag_q      <= 16'd0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            result_q   <= 16'd0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
            inexact_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            sign_q     <= sign_d;
            left_q     <= left_d;
            count_q    <= count_d;
            mag_q      <= mag_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            invalid_q  <= invalid_d;
            inexact_q  <= inexact_d;
        end
    end

endmodule
